// File: rtl/obstacle_scroller.sv
// Scrolling obstacle field: two mountains and one lava blob, with run/halt control,
// LFSR respawn heights and a saturating score. Optional macro: OBSTACLE_SCROLLER_SPEEDUP_EN.
module obstacle_scroller #(
    parameter int SCREEN_W  = 160,
    parameter int SPACING   = 80,
    parameter int SPEED     = 1,
    parameter int MTN_MIN_Y = 40,
    parameter int LAVA_Y    = 100
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       game_over,
    output logic [9:0] mountain1_x,
    output logic [9:0] mountain1_y,
    output logic [9:0] mountain2_x,
    output logic [9:0] mountain2_y,
    output logic [9:0] lava_x,
    output logic [7:0] score,
    output logic       running
);

    // state | meaning
    // IDLE  | field parked at reset positions, waiting for start
    // RUN   | field advances on each frame tick
    // HALT  | frozen after game_over, waiting for start to re-arm
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [9:0] X_RESP   = 10'(SCREEN_W - 1);
    localparam logic [9:0] M2_X0    = 10'(SCREEN_W - 1 - SPACING);
    localparam logic [9:0] LAVA_X0  = 10'(SCREEN_W - 1 - SPACING / 2);
    localparam logic [9:0] Y_BASE   = 10'(MTN_MIN_Y);
    localparam logic [9:0] Y0       = 10'(MTN_MIN_Y + 63);
    localparam logic [9:0] LFSR0    = 10'h2A5;

    if (SCREEN_W > 1023 || LAVA_Y > 1023) begin : g_bad_cfg
        $error("obstacle_scroller: coordinates must fit in 10 bits");
    end

    logic [1:0] state;
    logic [9:0] lfsr;
    logic [9:0] speed;

`ifdef OBSTACLE_SCROLLER_SPEEDUP_EN
    logic [1:0] boost;
    always_comb begin
        boost = score[5:4];
        if (score[7:6] != 2'b00) boost = 2'd3;
        speed = 10'(SPEED) + {8'd0, boost};
    end
`else
    always_comb speed = 10'(SPEED);
`endif

    logic       m1_resp, m2_resp, lava_resp;
    logic [9:0] m1_x_next, m2_x_next, lava_x_next;
    logic [9:0] m1_y_new, m2_y_new;
    logic [8:0] score_sum;
    logic [7:0] score_next;
    logic [9:0] lfsr_next;

    always_comb begin
        m1_resp     = mountain1_x < speed;
        m2_resp     = mountain2_x < speed;
        lava_resp   = lava_x < speed;
        m1_x_next   = m1_resp   ? X_RESP : mountain1_x - speed;
        m2_x_next   = m2_resp   ? X_RESP : mountain2_x - speed;
        lava_x_next = lava_resp ? X_RESP : lava_x - speed;
        // heights come from the LFSR value before this tick's advance
        m1_y_new    = Y_BASE + {4'd0, lfsr[5:0]};
        m2_y_new    = Y_BASE + {4'd0, lfsr[9:4]};
        score_sum   = {1'b0, score} + {8'd0, m1_resp} + {8'd0, m2_resp};
        score_next  = score_sum[8] ? 8'hFF : score_sum[7:0];
        lfsr_next   = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            running     <= 1'b0;
            lfsr        <= LFSR0;
            mountain1_x <= X_RESP;
            mountain2_x <= M2_X0;
            lava_x      <= LAVA_X0;
            mountain1_y <= Y0;
            mountain2_y <= Y0;
            score       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // a simultaneous game_over wins over the frame tick
                    if (game_over) begin
                        state   <= HALT;
                        running <= 1'b0;
                    end else if (frame_tick) begin
                        mountain1_x <= m1_x_next;
                        mountain2_x <= m2_x_next;
                        lava_x      <= lava_x_next;
                        if (m1_resp) mountain1_y <= m1_y_new;
                        if (m2_resp) mountain2_y <= m2_y_new;
                        score       <= score_next;
                        lfsr        <= lfsr_next;
                    end
                end
                HALT: begin
                    if (start) begin
                        state       <= IDLE;
                        mountain1_x <= X_RESP;
                        mountain2_x <= M2_X0;
                        lava_x      <= LAVA_X0;
                        mountain1_y <= Y0;
                        mountain2_y <= Y0;
                        score       <= 8'd0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench for obstacle_scroller: directed scenarios plus a randomized run
// against a frame-level reference model of the obstacle field.
module tb_obstacle_scroller;

    localparam int SCREEN_W  = 160;
    localparam int SPACING   = 80;
    localparam int SPEED     = 1;
    localparam int MTN_MIN_Y = 40;

    logic       clock = 1'b0;
    logic       resetn;
    logic       frame_tick, start, game_over;
    logic [9:0] mountain1_x, mountain1_y, mountain2_x, mountain2_y, lava_x;
    logic [7:0] score;
    logic       running;

    obstacle_scroller dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .start      (start),
        .game_over  (game_over),
        .mountain1_x(mountain1_x),
        .mountain1_y(mountain1_y),
        .mountain2_x(mountain2_x),
        .mountain2_y(mountain2_y),
        .lava_x     (lava_x),
        .score      (score),
        .running    (running)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: 0 = parked, 1 = running, 2 = frozen
    int m_mode, m1x, m1y, m2x, m2y, lx, sc, lfsr;

    function automatic void model_reload();
        m1x = SCREEN_W - 1;
        m2x = SCREEN_W - 1 - SPACING;
        lx  = SCREEN_W - 1 - SPACING / 2;
        m1y = MTN_MIN_Y + 63;
        m2y = MTN_MIN_Y + 63;
        sc  = 0;
    endfunction

    function automatic void model_reset();
        model_reload();
        m_mode = 0;
        lfsr   = 'h2A5;
    endfunction

    function automatic void model_move();
        int spd;
        int passed;
        spd = SPEED;
`ifdef OBSTACLE_SCROLLER_SPEEDUP_EN
        spd = spd + ((sc / 16 > 3) ? 3 : sc / 16);
`endif
        passed = 0;
        if (m1x < spd) begin
            m1x = SCREEN_W - 1;
            m1y = MTN_MIN_Y + (lfsr % 64);
            passed++;
        end else m1x = m1x - spd;
        if (m2x < spd) begin
            m2x = SCREEN_W - 1;
            m2y = MTN_MIN_Y + ((lfsr / 16) % 64);
            passed++;
        end else m2x = m2x - spd;
        if (lx < spd) lx = SCREEN_W - 1;
        else lx = lx - spd;
        sc = (sc + passed > 255) ? 255 : sc + passed;
        lfsr = ((lfsr * 2) % 1024) | (((lfsr >> 9) ^ (lfsr >> 6)) & 1);
    endfunction

    function automatic void model_edge(input bit tk, input bit st, input bit go);
        case (m_mode)
            0: if (st) m_mode = 1;
            1: begin
                if (go) m_mode = 2;
                else if (tk) model_move();
            end
            default: if (st) begin
                m_mode = 0;
                model_reload();
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input int exp);
        n_total++;
        assert (obs === 10'(exp)) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".m1x"}, mountain1_x, m1x);
        chk({tag, ".m1y"}, mountain1_y, m1y);
        chk({tag, ".m2x"}, mountain2_x, m2x);
        chk({tag, ".m2y"}, mountain2_y, m2y);
        chk({tag, ".lava"}, lava_x, lx);
        chk({tag, ".score"}, {2'b00, score}, sc);
        chk({tag, ".run"}, {9'd0, running}, (m_mode == 1) ? 1 : 0);
    endtask

    task automatic cyc(input bit tk, input bit st, input bit go, input string tag);
        @(negedge clock);
        frame_tick = tk;
        start      = st;
        game_over  = go;
        @(posedge clock);
        model_edge(tk, st, go);
        #1;
        compare_all(tag);
    endtask

    task automatic chk_reset_consts(input string tag);
        chk({tag, ".m1x"}, mountain1_x, 159);
        chk({tag, ".m1y"}, mountain1_y, 103);
        chk({tag, ".m2x"}, mountain2_x, 79);
        chk({tag, ".m2y"}, mountain2_y, 103);
        chk({tag, ".lava"}, lava_x, 119);
        chk({tag, ".score"}, {2'b00, score}, 0);
        chk({tag, ".run"}, {9'd0, running}, 0);
    endtask

    initial begin
        int guard;
        int prev;
        bit fast_done;
        resetn     = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        game_over  = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk_reset_consts("rst");
        @(negedge clock);
        resetn = 1'b1;

        repeat (5) cyc(1, 0, 0, "idle_tick");
        chk("idle_m1x", mountain1_x, 159);

        cyc(0, 1, 0, "start");
        chk("start_run", {9'd0, running}, 1);
        repeat (10) cyc(1, 0, 0, "tick10");
        chk("t10_m1x", mountain1_x, 149);
        chk("t10_m2x", mountain2_x, 69);
        chk("t10_lava", lava_x, 109);

        repeat (70) cyc(1, 0, 0, "tick80");
        chk("t80_m2x", mountain2_x, 159);
        chk("t80_m1x", mountain1_x, 79);
        chk("t80_score", {2'b00, score}, 1);

        cyc(1, 0, 1, "halt");
        chk("halt_run", {9'd0, running}, 0);
        chk("halt_m1x", mountain1_x, 79);
        repeat (5) cyc(1, 0, 0, "halt_tick");
        chk("halt_hold_m1x", mountain1_x, 79);
        cyc(1, 1, 0, "rearm");
        chk_reset_consts("rearm");
        cyc(0, 1, 0, "restart");
        chk("restart_run", {9'd0, running}, 1);

        guard     = 0;
        fast_done = 1'b0;
        while (sc < 255 && guard < 60000) begin
`ifdef OBSTACLE_SCROLLER_SPEEDUP_EN
            if (!fast_done && sc >= 48) begin
                prev = int'(mountain1_x);
                cyc(1, 0, 0, "fast");
                chk("fast_delta", mountain1_x, (prev < 4) ? 159 : prev - 4);
                fast_done = 1'b1;
            end
`endif
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 0, "rand");
            guard++;
        end
        chk("sat_reached", {2'b00, score}, 255);
        repeat (100) cyc(1, $urandom_range(0, 1) == 1, 0, "sat");
        chk("sat_hold", {2'b00, score}, 255);

        cyc(1, 0, 0, "pre_rst");
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_consts("async_rst");
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        cyc(0, 0, 0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/obstacle_scroller.md
# obstacle_scroller

Generates the scrolling obstacle field: positions of two mountains and one lava blob. The positions are advanced once per video frame and feed the collision checker and the VGA drawing logic. A run/halt state machine freezes the field when the collision checker raises `game_over`. Respawned mountain heights come from an on-chip LFSR, and the block keeps a saturating count of obstacles passed.

## Interface
- `SCREEN_W`, 160: playfield width in pixels; respawn x = `SCREEN_W-1`.
- `SPACING`, 80: initial horizontal gap between mountain1 and mountain2.
- `SPEED`, 1: pixels moved per frame tick (base speed).
- `MTN_MIN_Y`, 40: smallest mountain top y; heights span `MTN_MIN_Y` to `MTN_MIN_Y+63`.
- `LAVA_Y`, 100: fixed lava row; informational, not an output.

Ports:
- `clock` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse, once per frame.
- `start` in 1: level; begins a run, or re-arms after a halt.
- `game_over` in 1: from the collision checker; freezes the field.
- `mountain1_x`, `mountain1_y`, `mountain2_x`, `mountain2_y` out 10 each: mountain positions.
- `lava_x` out 10: lava position.
- `score` out 8: obstacles passed, saturating at 255.
- `running` out 1: high while in RUN.

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE → RUN when `start`=1; `game_over` is ignored in IDLE.
  - RUN → HALT when `game_over`=1.
  - HALT → IDLE when `start`=1. Entering IDLE from HALT reloads positions, heights and `score` to their reset values. The LFSR is not reloaded.
- Reset values (async):
  - state IDLE
  - `mountain1_x` = `SCREEN_W-1`
  - `mountain2_x` = `SCREEN_W-1-SPACING`
  - `lava_x` = `SCREEN_W-1-SPACING/2`
  - both mountain y = `MTN_MIN_Y+63`
  - `score` 0, `running` 0
  - LFSR 10'h2A5
- Movement, only in RUN on `frame_tick`=1 with `game_over`=0:
  - Each x decreases by the current speed.
  - If x < speed, that object respawns at x = `SCREEN_W-1` instead; no negative wrap ever appears.
- LFSR: 10-bit Fibonacci, next = {q[8:0], q[9]^q[6]}. It advances once per qualifying `frame_tick`, only in RUN.
- Respawn heights are taken from the pre-advance LFSR value:
  - mountain1_y = `MTN_MIN_Y` + q[5:0]
  - mountain2_y = `MTN_MIN_Y` + q[9:4]
  - Both may respawn on the same tick, each using its own slice.
  - Lava respawns x only.
- `score` increments by 1 per mountain respawn (by 2 if both respawn on the same tick) and saturates at 255. Lava respawns do not score.
- All arithmetic is 10-bit unsigned. `SCREEN_W` must be ≤ 1023.

## Timing
- All outputs are registered. A qualifying `frame_tick` sampled at edge N produces the new positions and `score` after edge N.
- `game_over` sampled together with `frame_tick` in RUN: the halt wins, and positions, LFSR and `score` are unchanged.
- HALT holds all outputs stable indefinitely.
- `running` follows the state register; it drops on the edge that enters HALT.
- Reset asserted mid-run returns all outputs to reset values immediately, without waiting for a clock.
- `frame_tick` in IDLE or HALT has no effect.
- `start` held high across HALT → IDLE → RUN takes two edges: HALT→IDLE on the first, IDLE→RUN on the second.

## Configuration
- Macro: `OBSTACLE_SCROLLER_SPEEDUP_EN`.
- Defined: current speed = `SPEED` + min(`score`[7:4], 3). Speed rises by one every 16 points, up to `SPEED`+3. The x < speed respawn rule uses this current speed.
- Undefined: speed is constant `SPEED`; `score` still counts.

## Test plan
- Reset with defaults: outputs are 159/103, 79/103, lava 119, score 0, running 0. With no `start`, 5 ticks change nothing.
- `start`, then 10 ticks: m1_x=149, m2_x=69, lava_x=109, running=1.
- From start, 80 ticks: tick 80 respawns m2 at x=159 with y = 40 + LFSR[9:4], matched against a bit-accurate LFSR model. Score=1. m1_x=79.
- `game_over` and `frame_tick` in the same cycle during RUN: positions unchanged, running=0. Further ticks have no effect. `start` → IDLE with reset positions; `start` again → RUN.
- Run until score reaches 255, keep ticking: score stays 255. With `OBSTACLE_SCROLLER_SPEEDUP_EN` defined, verify a per-tick delta of 1 at score 0 and 4 at score ≥ 48.
- Assert `resetn` low mid-run while between clock edges: outputs return to reset values before the next edge.
